// File: rtl/odd_parity_frame_checker.sv
// Serial odd-parity frame receiver: gathers DATA_W data bits LSB first plus one parity bit,
// checks odd parity and hands the word downstream through a valid/ready output register.
module odd_parity_frame_checker #(
   parameter int DATA_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              bit_ready,
   input  logic              sync,
   output logic [DATA_W-1:0] data_out,
   output logic              parity_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2
   } state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   shreg_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   data_q;
   logic                perr_q;
   logic                out_valid_q;
   logic [CNT_W-1:0]    frame_cnt_q;
   logic [CNT_W-1:0]    err_cnt_q;

   logic                accept_d;
   logic                perr_d;
   logic [CNT_W-1:0]    frame_cnt_d;
   logic [CNT_W-1:0]    err_cnt_d;

   // A frame is good when data plus parity bit hold an odd number of ones.
   function automatic logic odd_parity_err(input logic [DATA_W-1:0] data, input logic par);
      return ~(^data ^ par);
   endfunction

   // Only the parity bit stalls, and only while the previous frame is still unclaimed.
   assign bit_ready  = !((state_q == S_PARITY) && out_valid_q && !out_ready);
   assign accept_d   = bit_valid && bit_ready;

   assign data_out   = data_q;
   assign parity_err = perr_q;
   assign out_valid  = out_valid_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_cnt    = err_cnt_q;

   // Parity verdict and saturating counter next values for a frame completing this cycle.
   always_comb begin
      perr_d = odd_parity_err(shreg_q, bit_in);
      if (frame_cnt_q == CNT_MAX) begin
         frame_cnt_d = frame_cnt_q;
      end else begin
         frame_cnt_d = frame_cnt_q + CNT_ONE;
      end
      if (perr_d && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_ONE;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Frame FSM, shift register and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         shreg_q     <= {DATA_W{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         data_q      <= {DATA_W{1'b0}};
         perr_q      <= 1'b0;
         out_valid_q <= 1'b0;
         frame_cnt_q <= {CNT_W{1'b0}};
         err_cnt_q   <= {CNT_W{1'b0}};
      end else begin
         // Consumption first; a frame completing at the same edge overrides it below.
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end else begin
            out_valid_q <= out_valid_q;
         end

         if (sync) begin
            state_q <= S_IDLE;
            shreg_q <= {DATA_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
         end else if (accept_d) begin
            case (state_q)
               S_IDLE, S_DATA: begin
                  shreg_q[idx_q] <= bit_in;
                  if (idx_q == IDX_LAST) begin
                     state_q <= S_PARITY;
                     idx_q   <= {IDX_W{1'b0}};
                  end else begin
                     state_q <= S_DATA;
                     idx_q   <= idx_q + IDX_ONE;
                  end
               end
               S_PARITY: begin
                  data_q      <= shreg_q;
                  perr_q      <= perr_d;
                  out_valid_q <= 1'b1;
                  frame_cnt_q <= frame_cnt_d;
                  err_cnt_q   <= err_cnt_d;
                  state_q     <= S_IDLE;
                  shreg_q     <= {DATA_W{1'b0}};
                  idx_q       <= {IDX_W{1'b0}};
               end
               default: begin
                  state_q <= S_IDLE;
                  shreg_q <= {DATA_W{1'b0}};
                  idx_q   <= {IDX_W{1'b0}};
               end
            endcase
         end else begin
            state_q <= state_q;
         end
      end
   end

endmodule

// File: tb/tb_odd_parity_frame_checker.sv
// Bench for odd_parity_frame_checker: directed scenarios plus random traffic against a
// frame-level model; a second instance with 2-bit counters covers saturation.
module tb_odd_parity_frame_checker;
   localparam int DW = 3;

   logic clk = 1'b0;
   logic rst_n, bit_in, bit_valid, sync, out_ready;
   logic bit_ready, parity_err, out_valid;
   logic [DW-1:0] data_out;
   logic [7:0] frame_cnt, err_cnt;
   logic bit_ready_s, parity_err_s, out_valid_s;
   logic [DW-1:0] data_out_s;
   logic [1:0] frame_cnt_s, err_cnt_s;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Frame-level model
   bit m_bits[$];
   logic [DW-1:0] m_data;
   logic m_perr, m_ov;
   int m_fc, m_ec, m_fc2, m_ec2;

   always #5 clk = ~clk;

   odd_parity_frame_checker #(.DATA_W(DW), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .sync(sync), .data_out(data_out),
      .parity_err(parity_err), .out_valid(out_valid), .out_ready(out_ready),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt));

   odd_parity_frame_checker #(.DATA_W(DW), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready_s), .sync(sync), .data_out(data_out_s),
      .parity_err(parity_err_s), .out_valid(out_valid_s), .out_ready(out_ready),
      .frame_cnt(frame_cnt_s), .err_cnt(err_cnt_s));

   function automatic logic exp_ready();
      return !(m_bits.size() == DW && m_ov && !out_ready);
   endfunction

   // Drive one cycle of inputs, advance the model, and land on the next falling edge.
   task automatic tick(input logic v, input logic b, input logic s, input logic r);
      int ones;
      logic acc;
      bit_valid = v; bit_in = b; sync = s; out_ready = r;
      acc = v && exp_ready();
      if (m_ov && r) m_ov = 1'b0;
      if (s) begin
         m_bits.delete();
      end else if (acc) begin
         if (m_bits.size() == DW) begin
            ones = b;
            m_data = '0;
            for (int k = 0; k < DW; k++) begin
               ones += m_bits[k];
               if (m_bits[k]) m_data = m_data + DW'(1 << k);
            end
            m_perr = (ones % 2 == 0);
            m_ov = 1'b1;
            m_fc = (m_fc + 1 > 255) ? 255 : m_fc + 1;
            m_fc2 = (m_fc2 + 1 > 3) ? 3 : m_fc2 + 1;
            if (m_perr) begin
               m_ec = (m_ec + 1 > 255) ? 255 : m_ec + 1;
               m_ec2 = (m_ec2 + 1 > 3) ? 3 : m_ec2 + 1;
            end
            m_bits.delete();
         end else begin
            m_bits.push_back(b);
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_clear();
      m_bits.delete();
      m_data = '0; m_perr = 1'b0; m_ov = 1'b0;
      m_fc = 0; m_ec = 0; m_fc2 = 0; m_ec2 = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bit_valid = 1'b0; bit_in = 1'b0; sync = 1'b0; out_ready = 1'b0;
      model_clear();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++;
      if ({data_out, parity_err, out_valid, frame_cnt, err_cnt, bit_ready} !== {3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1})
         $display("FAIL reset_initial: got data=%0d perr=%0d ov=%0d fc=%0d ec=%0d rdy=%0d, want 0 0 0 0 0 1",
                  data_out, parity_err, out_valid, frame_cnt, err_cnt, bit_ready);
      else pass_cnt++;
      tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      tick(1, 1, 0, 0); tick(1, 0, 0, 0);
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL reset_pre_ov: got %0d want 1", out_valid);
      else pass_cnt++;
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      bit_valid = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({data_out, parity_err, out_valid, frame_cnt, err_cnt, bit_ready} !== {3'b000, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1})
         $display("FAIL reset_midframe: got data=%0d perr=%0d ov=%0d fc=%0d ec=%0d rdy=%0d, want 0 0 0 0 0 1",
                  data_out, parity_err, out_valid, frame_cnt, err_cnt, bit_ready);
      else pass_cnt++;
      tick(1, 0, 0, 1); tick(1, 1, 0, 1); tick(1, 1, 0, 1); tick(1, 1, 0, 1);
      total_cnt++;
      if ({data_out, parity_err, out_valid, frame_cnt} !== {3'b110, 1'b0, 1'b1, 8'd1})
         $display("FAIL reset_fresh_frame: got data=%b perr=%0d ov=%0d fc=%0d, want 110 0 1 1",
                  data_out, parity_err, out_valid, frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_good_frame();
      do_reset();
      tick(1, 1, 0, 1); tick(1, 0, 0, 1); tick(1, 1, 0, 1); tick(1, 1, 0, 1);
      total_cnt++;
      if ({data_out, parity_err, out_valid, frame_cnt, err_cnt} !== {3'b101, 1'b0, 1'b1, 8'd1, 8'd0})
         $display("FAIL good_frame: got data=%b perr=%0d ov=%0d fc=%0d ec=%0d, want 101 0 1 1 0",
                  data_out, parity_err, out_valid, frame_cnt, err_cnt);
      else pass_cnt++;
      tick(0, 0, 0, 1);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL good_frame_ov_pulse: got %0d want 0", out_valid);
      else pass_cnt++;
   endtask

   task automatic test_bad_frame();
      do_reset();
      tick(1, 1, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1); tick(1, 1, 0, 1);
      total_cnt++;
      if ({data_out, parity_err} !== {3'b011, 1'b0})
         $display("FAIL bad_frame_first: got data=%b perr=%0d, want 011 0", data_out, parity_err);
      else pass_cnt++;
      tick(1, 1, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1); tick(1, 0, 0, 1);
      total_cnt++;
      if ({parity_err, frame_cnt, err_cnt} !== {1'b1, 8'd2, 8'd1})
         $display("FAIL bad_frame: got perr=%0d fc=%0d ec=%0d, want 1 2 1", parity_err, frame_cnt, err_cnt);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 0, 0, 0);
      tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      tick(1, 1, 0, 0);
      total_cnt++;
      if ({bit_ready, data_out, out_valid, frame_cnt} !== {1'b0, 3'b001, 1'b1, 8'd1})
         $display("FAIL backpressure_stall: got rdy=%0d data=%b ov=%0d fc=%0d, want 0 001 1 1",
                  bit_ready, data_out, out_valid, frame_cnt);
      else pass_cnt++;
      tick(1, 1, 0, 1);
      total_cnt++;
      if ({data_out, parity_err, out_valid, frame_cnt} !== {3'b110, 1'b0, 1'b1, 8'd2})
         $display("FAIL backpressure_release: got data=%b perr=%0d ov=%0d fc=%0d, want 110 0 1 2",
                  data_out, parity_err, out_valid, frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_sync();
      do_reset();
      tick(1, 1, 0, 1); tick(1, 1, 0, 1); tick(1, 1, 1, 1);
      tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(1, 1, 0, 1);
      total_cnt++;
      if ({data_out, parity_err, out_valid, frame_cnt} !== {3'b000, 1'b0, 1'b1, 8'd1})
         $display("FAIL sync_abort: got data=%b perr=%0d ov=%0d fc=%0d, want 000 0 1 1",
                  data_out, parity_err, out_valid, frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int f = 1; f <= 5; f++) begin
         tick(1, 1, 0, 1); tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(1, 1, 0, 1);
         if (f >= 3) begin
            total_cnt++;
            if ({frame_cnt_s, err_cnt_s, parity_err_s} !== {2'd3, 2'd3, 1'b1})
               $display("FAIL saturation_f%0d: got fc=%0d ec=%0d perr=%0d, want 3 3 1",
                        f, frame_cnt_s, err_cnt_s, parity_err_s);
            else pass_cnt++;
         end
      end
      total_cnt++;
      if ({frame_cnt, err_cnt} !== {8'd5, 8'd5})
         $display("FAIL saturation_wide: got fc=%0d ec=%0d, want 5 5", frame_cnt, err_cnt);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4 * (DW + 1); i++) begin
         tick(1, 1'($urandom_range(0, 1)), 0, 1);
         total_cnt++;
         if ({bit_ready, data_out, parity_err, out_valid, frame_cnt, err_cnt} !==
             {1'b1, m_data, m_perr, m_ov, 8'(m_fc), 8'(m_ec)})
            $display("FAIL back_to_back[%0d]: got rdy=%0d data=%b perr=%0d ov=%0d fc=%0d ec=%0d, want 1 %b %0d %0d %0d %0d",
                     i, bit_ready, data_out, parity_err, out_valid, frame_cnt, err_cnt,
                     m_data, m_perr, m_ov, m_fc, m_ec);
         else pass_cnt++;
      end
      total_cnt++;
      if (frame_cnt !== 8'd4) $display("FAIL back_to_back_count: got %0d want 4", frame_cnt);
      else pass_cnt++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 2) != 0));
         total_cnt++;
         if ({bit_ready, data_out, parity_err, out_valid, frame_cnt, err_cnt, frame_cnt_s, err_cnt_s, bit_ready_s} !==
             {exp_ready(), m_data, m_perr, m_ov, 8'(m_fc), 8'(m_ec), 2'(m_fc2), 2'(m_ec2), exp_ready()})
            $display("FAIL random[%0d]: got rdy=%0d data=%b perr=%0d ov=%0d fc=%0d ec=%0d fc2=%0d ec2=%0d, want %0d %b %0d %0d %0d %0d %0d %0d",
                     i, bit_ready, data_out, parity_err, out_valid, frame_cnt, err_cnt, frame_cnt_s, err_cnt_s,
                     exp_ready(), m_data, m_perr, m_ov, m_fc, m_ec, m_fc2, m_ec2);
         else pass_cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bit_valid = 1'b0; bit_in = 1'b0; sync = 1'b0; out_ready = 1'b0;
      model_clear();
      test_reset();
      test_good_frame();
      test_bad_frame();
      test_backpressure();
      test_sync();
      test_saturation();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
